// File: rtl/mc_sequencer_pkg.sv
// Shared types for the multi-cycle sequencer: FSM states, PC source select, opcodes, opcode class.
// Latency/backpressure: none (declarations only).
package ctrl_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        PC_PLUS4  = 2'd0,
        PC_BRANCH = 2'd1,
        PC_JALR   = 2'd2,
        PC_TRAP   = 2'd3
    } pc_sel_t;

    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;

    // One-hot instruction class; exactly one field is set for any opcode.
    typedef struct packed {
        logic alu;
        logic load;
        logic store;
        logic branch;
        logic jal;
        logic jalr;
        logic illegal;
    } opc_class_t;

endpackage

// File: rtl/mc_sequencer_if.sv
// Unified memory port between the sequencer (master) and the memory (slave).
// Request is level-held until mem_ack; the slave may insert any number of wait cycles.
interface mc_sequencer_if;
    logic mem_req;
    logic mem_we;
    logic addr_sel;
    logic mem_ack;

    modport master (output mem_req, output mem_we, output addr_sel, input mem_ack);
    modport slave  (input mem_req, input mem_we, input addr_sel, output mem_ack);
endinterface

// File: rtl/mc_sequencer_opc_class.sv
// Opcode classifier: 7-bit opcode to one-hot class; anything unrecognised is illegal.
// Purely combinational, zero latency, no backpressure.
module opc_class
    import ctrl_pkg::*;
(
    input  logic [6:0]  opcode,
    output opc_class_t  cls
);
    always_comb begin
        cls = '0;
        case (opcode)
            OP, OP_IMM, LUI, AUIPC: cls.alu     = 1'b1;
            LOAD:                   cls.load    = 1'b1;
            STORE:                  cls.store   = 1'b1;
            BRANCH:                 cls.branch  = 1'b1;
            JAL:                    cls.jal     = 1'b1;
            JALR:                   cls.jalr    = 1'b1;
            default:                cls.illegal = 1'b1;
        endcase
    end
endmodule

// File: rtl/mc_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer; outputs are combinational from state, only instret is registered.
// Memory stalls by withholding mem_ack; define XRV_ILLEGAL_TRAP_EN to trap illegal opcodes instead of retiring them as NOP.
module mc_sequencer
    import ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    mc_sequencer_if.master     mem,
    input  logic               run,
    input  logic [6:0]         opcode,
    input  logic               branch_taken,
    output logic               ir_we,
    output logic               rf_en,
    output logic               pc_we,
    output logic [1:0]         pc_sel,
    output logic               trap,
    output logic [CNT_W-1:0]   instret
);

    state_t     state, state_nxt;
    logic       fetch_pend, fetch_pend_nxt;
    logic       retire;
    opc_class_t cls;
    pc_sel_t    pc_sel_d;
    logic       req_d, we_d, asel_d, ir_we_d, rf_en_d, pc_we_d, trap_d;

    opc_class u_opc_class (
        .opcode (opcode),
        .cls    (cls)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_FETCH;
            fetch_pend <= 1'b0;
            instret    <= '0;
        end else begin
            state      <= state_nxt;
            fetch_pend <= fetch_pend_nxt;
            if (retire) begin
                instret <= instret + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_nxt      = state;
        fetch_pend_nxt = fetch_pend;
        retire         = 1'b0;
        pc_sel_d       = PC_PLUS4;
        req_d          = 1'b0;
        we_d           = 1'b0;
        asel_d         = 1'b0;
        ir_we_d        = 1'b0;
        rf_en_d        = 1'b0;
        pc_we_d        = 1'b0;
        trap_d         = 1'b0;

        case (state)
            S_FETCH: begin
                // Once issued, a fetch stays up until acked even if run drops.
                if (run || fetch_pend) begin
                    req_d = 1'b1;
                    if (mem.mem_ack) begin
                        ir_we_d        = 1'b1;
                        fetch_pend_nxt = 1'b0;
                        state_nxt      = S_DECODE;
                    end else begin
                        fetch_pend_nxt = 1'b1;
                    end
                end
            end
            S_DECODE: begin
                if (cls.illegal) begin
`ifdef XRV_ILLEGAL_TRAP_EN
                    state_nxt = S_TRAP;
`else
                    pc_we_d   = 1'b1;
                    retire    = 1'b1;
                    state_nxt = S_FETCH;
`endif
                end else begin
                    state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                if (cls.branch) begin
                    pc_we_d   = 1'b1;
                    pc_sel_d  = branch_taken ? PC_BRANCH : PC_PLUS4;
                    retire    = 1'b1;
                    state_nxt = S_FETCH;
                end else if (cls.load || cls.store) begin
                    state_nxt = S_MEM;
                end else if (cls.alu || cls.jal || cls.jalr) begin
                    state_nxt = S_WB;
                end else begin
                    state_nxt = S_FETCH;
                end
            end
            S_MEM: begin
                req_d  = 1'b1;
                asel_d = 1'b1;
                we_d   = cls.store;
                if (mem.mem_ack) begin
                    // A store retires on its own ack: no writeback stage follows.
                    if (cls.store) begin
                        pc_we_d   = 1'b1;
                        retire    = 1'b1;
                        state_nxt = S_FETCH;
                    end else begin
                        state_nxt = S_WB;
                    end
                end
            end
            S_WB: begin
                rf_en_d   = 1'b1;
                pc_we_d   = 1'b1;
                retire    = 1'b1;
                pc_sel_d  = cls.jal ? PC_BRANCH : (cls.jalr ? PC_JALR : PC_PLUS4);
                state_nxt = S_FETCH;
            end
            S_TRAP: begin
`ifdef XRV_ILLEGAL_TRAP_EN
                trap_d   = 1'b1;
                pc_we_d  = 1'b1;
                pc_sel_d = PC_TRAP;
`endif
                state_nxt = S_FETCH;
            end
            default: state_nxt = S_FETCH;
        endcase
    end

    // Outputs are forced low for the whole reset assertion, not just after the first edge.
    assign mem.mem_req  = rst_n & req_d;
    assign mem.mem_we   = rst_n & we_d;
    assign mem.addr_sel = rst_n & asel_d;
    assign ir_we        = rst_n & ir_we_d;
    assign rf_en        = rst_n & rf_en_d;
    assign pc_we        = rst_n & pc_we_d;
    assign trap         = rst_n & trap_d;
    assign pc_sel       = rst_n ? pc_sel_d : PC_PLUS4;

endmodule

// File: tb/tb_mc_sequencer.sv
// Scoreboard bench for mc_sequencer: randomized program, memory waits and run toggling against a per-instruction reference model.
module tb_mc_sequencer;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          run = 1'b0;
    logic          branch_taken = 1'b0;
    logic [6:0]    opcode = 7'h0;
    logic          ir_we, rf_en, pc_we, trap;
    logic [1:0]    pc_sel;
    logic [CW-1:0] instret;

    mc_sequencer_if mem ();

    mc_sequencer #(.CNT_W(CW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mem          (mem),
        .run          (run),
        .opcode       (opcode),
        .branch_taken (branch_taken),
        .ir_we        (ir_we),
        .rf_en        (rf_en),
        .pc_we        (pc_we),
        .pc_sel       (pc_sel),
        .trap         (trap),
        .instret      (instret)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0] op;
        logic       bt;
        int         fw;
        int         mw;
    } ins_t;

    typedef struct {
        int            cyc;
        int            freq;
        int            mreq;
        int            mwe;
        int            rf;
        int            trp;
        logic [1:0]    psel;
        logic [CW-1:0] ib;
    } exp_t;

    ins_t prog[$];
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 0, resp_en = 0, tog_en = 0, prog_done = 0;
    int   rm = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic bit retires(input logic [6:0] op);
        bit legal;
        legal = (op == 7'h33 || op == 7'h13 || op == 7'h37 || op == 7'h17 || op == 7'h6F ||
                 op == 7'h67 || op == 7'h03 || op == 7'h23 || op == 7'h63);
`ifdef XRV_ILLEGAL_TRAP_EN
        return legal;
`else
        return 1'b1;
`endif
    endfunction

    // Expected end-of-instruction picture, derived from the instruction class and wait counts.
    function automatic exp_t model(input ins_t i, input int retired);
        exp_t e;
        e.freq = i.fw + 1;
        e.mreq = 0;
        e.mwe  = 0;
        e.rf   = 0;
        e.trp  = 0;
        e.psel = 2'd0;
        e.ib   = retired[CW-1:0];
        case (i.op)
            7'h33, 7'h13, 7'h37, 7'h17: begin e.cyc = 4 + i.fw; e.rf = 1; end
            7'h6F: begin e.cyc = 4 + i.fw; e.rf = 1; e.psel = 2'd1; end
            7'h67: begin e.cyc = 4 + i.fw; e.rf = 1; e.psel = 2'd2; end
            7'h03: begin e.cyc = 5 + i.fw + i.mw; e.mreq = i.mw + 1; e.rf = 1; end
            7'h23: begin e.cyc = 4 + i.fw + i.mw; e.mreq = i.mw + 1; e.mwe = i.mw + 1; end
            7'h63: begin e.cyc = 3 + i.fw; e.psel = i.bt ? 2'd1 : 2'd0; end
            default: begin
`ifdef XRV_ILLEGAL_TRAP_EN
                e.cyc = 3 + i.fw; e.trp = 1; e.psel = 2'd3;
`else
                e.cyc = 2 + i.fw;
`endif
            end
        endcase
        return e;
    endfunction

    function automatic ins_t mk(input logic [6:0] op, input logic bt, input int fw, input int mw);
        ins_t i;
        i.op = op; i.bt = bt; i.fw = fw; i.mw = mw;
        return i;
    endfunction

    // Memory model: pops the next instruction on each new fetch and pushes its expectation.
    ins_t cur;
    int   wcnt = 0;
    bit   in_req = 0;
    always @(negedge clk) begin
        if (resp_en) begin
            if (mem.mem_req) begin
                if (!in_req) begin
                    if (!mem.addr_sel) begin
                        if (prog.size() != 0) begin
                            cur = prog.pop_front();
                            sb.push_back(model(cur, rm));
                            rm += retires(cur.op) ? 1 : 0;
                            if (prog.size() == 0) prog_done = 1;
                            wcnt = cur.fw;
                            in_req = 1;
                        end
                    end else begin
                        wcnt = cur.mw;
                        in_req = 1;
                    end
                end
                if (in_req) begin
                    if (wcnt == 0) begin
                        mem.mem_ack = 1'b1;
                        in_req = 0;
                        if (!mem.addr_sel) begin
                            opcode = cur.op;
                            branch_taken = cur.bt;
                        end
                    end else begin
                        mem.mem_ack = 1'b0;
                        wcnt--;
                    end
                end else begin
                    mem.mem_ack = 1'b0;
                end
            end else begin
                mem.mem_ack = 1'($urandom % 2);
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (tog_en) run = !prog_done && ($urandom % 4 != 0);
    end

    // Monitor: accumulates one instruction's activity and compares when pc_we marks its end.
    int cyc_a = 0, f_a = 0, m_a = 0, w_a = 0, rf_a = 0, ir_a = 0, tr_a = 0;
    bit act = 0;
    always @(negedge clk) begin
        #2;
        if (mon_en) begin
            if (mem.mem_req && mem.mem_we) chk("no_rf_ir_during_store", {30'd0, rf_en, ir_we}, 0);
            if (mem.mem_we) chk("mem_we_implies_req", mem.mem_req, 1);
            if (trap) chk("trap_with_pc_we", pc_we, 1);
            if (mem.mem_req) act = 1;
            if (act) begin
                cyc_a++;
                if (mem.mem_req && !mem.addr_sel) f_a++;
                if (mem.mem_req && mem.addr_sel) m_a++;
                if (mem.mem_we) w_a++;
                rf_a += rf_en ? 1 : 0;
                ir_a += ir_we ? 1 : 0;
                tr_a += trap ? 1 : 0;
            end
            if (pc_we) begin
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_retire: pc_we with no outstanding instruction (t=%0t)", $time);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("instr_cycles", cyc_a, e.cyc);
                    chk("fetch_req_cycles", f_a, e.freq);
                    chk("mem_req_cycles", m_a, e.mreq);
                    chk("mem_we_cycles", w_a, e.mwe);
                    chk("rf_en_count", rf_a, e.rf);
                    chk("ir_we_count", ir_a, 1);
                    chk("trap_count", tr_a, e.trp);
                    chk("pc_sel", pc_sel, e.psel);
                    chk("instret_at_retire", instret, e.ib);
                end
                act = 0; cyc_a = 0; f_a = 0; m_a = 0; w_a = 0; rf_a = 0; ir_a = 0; tr_a = 0;
            end
        end
    end

    logic [6:0] ops [10] = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h23, 7'h63, 7'h7F};

    initial begin
        int idle_bad;
        int t;
        ins_t i;
        mem.mem_ack = 1'b0;
        run = 1'b1;
        #3;
        chk("reset_mem_req", mem.mem_req, 0);
        chk("reset_ir_we", ir_we, 0);
        chk("reset_pc_we", pc_we, 0);
        chk("reset_rf_en", rf_en, 0);
        chk("reset_trap", trap, 0);
        chk("reset_instret", instret, 0);

        run = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        idle_bad = 0;
        for (int k = 0; k < 10; k++) begin
            mem.mem_ack = 1'b1;
            @(negedge clk);
            #1;
            if (mem.mem_req || ir_we) idle_bad++;
        end
        chk("run0_idle_no_req", idle_bad, 0);
        mem.mem_ack = 1'b0;

        prog.push_back(mk(7'h13, 0, 0, 0));
        prog.push_back(mk(7'h03, 0, 2, 2));
        prog.push_back(mk(7'h23, 0, 0, 1));
        prog.push_back(mk(7'h63, 1, 0, 0));
        prog.push_back(mk(7'h7F, 0, 1, 0));
        for (int n = 0; n < 70; n++) begin
            i = mk(ops[$urandom_range(9)], 1'($urandom % 2), $urandom_range(2), $urandom_range(2));
            if (i.op == 7'h7F && ($urandom % 2 == 1)) i.op = 7'h0B;
            prog.push_back(i);
        end
        resp_en = 1; mon_en = 1; tog_en = 1;

        t = 0;
        while (t < 5000 && !(prog.size() == 0 && sb.size() == 0)) begin
            @(negedge clk);
            t++;
        end
        chk("program_completed", {31'd0, prog.size() == 0 && sb.size() == 0}, 1);
        tog_en = 0; run = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("final_instret", instret, rm % (1 << CW));
        mon_en = 0; resp_en = 0;
        @(negedge clk);
        mem.mem_ack = 1'b0;

        // Reset in the middle of a waiting load.
        run = 1'b1;
        #1;
        chk("directed_fetch_req", mem.mem_req, 1);
        mem.mem_ack = 1'b1; opcode = 7'h03;
        @(negedge clk); mem.mem_ack = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("mem_phase_req", mem.mem_req, 1);
        chk("mem_phase_addr_sel", mem.addr_sel, 1);
        rst_n = 1'b0;
        #1;
        chk("midreq_reset_mem_req", mem.mem_req, 0);
        chk("midreq_reset_rf_en", rf_en, 0);
        chk("midreq_reset_pc_we", pc_we, 0);
        chk("midreq_reset_instret", instret, 0);
        run = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("post_reset_idle", mem.mem_req, 0);
        run = 1'b1;
        #1;
        chk("post_reset_fetch_req", mem.mem_req, 1);
        chk("post_reset_fetch_addr", mem.addr_sel, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
